// File: rtl/push_pkg.sv
// push_pkg: shared round state encoding and index-width helper for the press race counter
package push_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  function automatic int clog2_min1(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/push_argmax.sv
// push_argmax: index of the largest count (lowest index wins ties) plus a shared-maximum flag
module push_argmax
  import push_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W = 8,
  parameter int IDX_W = clog2_min1(NUM_PLAYERS)
) (
  input  logic [NUM_PLAYERS*CNT_W-1:0] cnt_flat,
  output logic [IDX_W-1:0]             max_idx,
  output logic                         dup_max
);
  logic [CNT_W-1:0] best;
  // strict > keeps the earliest index on equality; a new strict max clears the dup flag
  always_comb begin
    max_idx = '0;
    best = cnt_flat[CNT_W-1:0];
    dup_max = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (cnt_flat[i*CNT_W +: CNT_W] > best) begin
        best = cnt_flat[i*CNT_W +: CNT_W];
        max_idx = IDX_W'(i);
        dup_max = 1'b0;
      end else if (cnt_flat[i*CNT_W +: CNT_W] == best) begin
        dup_max = 1'b1;
      end
    end
  end
endmodule

// File: rtl/push_race_counter.sv
// push_race_counter: N-player speed-round press counter with leader/tie; define PUSH_TARGET_EN for target finish
module push_race_counter
  import push_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W = 8,
  parameter int TARGET = 10,
  localparam int IDX_W = clog2_min1(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       pb,
  input  logic                         speedRound,
  input  logic                         speedExit,
  output logic [NUM_PLAYERS*CNT_W-1:0] cnt_flat,
  output logic [IDX_W-1:0]             speed_leader,
  output logic                         speed_lead,
  output logic                         speed_tie,
  output logic                         speed_done
);
`ifdef PUSH_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif
  state_t state, state_next;
  logic [NUM_PLAYERS-1:0] pb_q, press;
  logic [CNT_W-1:0] cnt [NUM_PLAYERS];
  logic [IDX_W-1:0] max_idx;
  logic dup_max, any_ge, hit, clr, inc_en;
  assign press = pb & ~pb_q;
  assign hit = TGT_EN && any_ge;
  always_comb begin
    any_ge = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) any_ge = any_ge | (cnt[i] >= CNT_W'(TARGET));
  end
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt[g];
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_next;
  end
  // speedExit outranks speedRound everywhere; reaching the target finishes the round
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (!speedExit && speedRound) ? COUNT : IDLE;
      COUNT:   state_next = (speedExit || !speedRound || hit) ? DONE : COUNT;
      DONE:    state_next = (!speedExit && !speedRound) ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    clr = state == IDLE && state_next == COUNT;
    inc_en = state == COUNT && !hit;
    speed_done = state == DONE;
  end
  // pb_q resets high so a button held through reset needs a fresh press
  always_ff @(posedge clk) begin
    if (!rst) pb_q <= '1;
    else pb_q <= pb;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!rst || clr) cnt[i] <= '0;
      else if (inc_en && press[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
  end
  push_argmax #(.NUM_PLAYERS(NUM_PLAYERS), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_argmax (
    .cnt_flat (cnt_flat),
    .max_idx  (max_idx),
    .dup_max  (dup_max)
  );
  always_ff @(posedge clk) begin
    if (!rst || state == IDLE) begin
      speed_leader <= '0;
      speed_lead <= 1'b0;
      speed_tie <= 1'b0;
    end else begin
      speed_leader <= max_idx;
      speed_lead <= !dup_max;
      speed_tie <= dup_max;
    end
  end
endmodule

// File: tb/tb_push_race_counter.sv
// tb_push_race_counter: directed checks of counting, leader/tie, saturation, reset and round control
module tb_push_race_counter;
  localparam int NP = 4;
  localparam int CW = 3;
`ifdef PUSH_TARGET_EN
  localparam bit TGT = 1'b1;
`else
  localparam bit TGT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, speedRound, speedExit;
  logic [NP-1:0] pb;
  logic [NP*CW-1:0] cnt_flat;
  logic [1:0] speed_leader;
  logic speed_lead, speed_tie, speed_done;
  int n_chk = 0;
  int n_pass = 0;
  push_race_counter #(.NUM_PLAYERS(NP), .CNT_W(CW), .TARGET(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pb           (pb),
    .speedRound   (speedRound),
    .speedExit    (speedExit),
    .cnt_flat     (cnt_flat),
    .speed_leader (speed_leader),
    .speed_lead   (speed_lead),
    .speed_tie    (speed_tie),
    .speed_done   (speed_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic press(input int i);
    pb[i] = 1'b1;
    tick();
    pb[i] = 1'b0;
    tick();
  endtask
  function automatic int cnt(input int i);
    return int'(cnt_flat[i*CW +: CW]);
  endfunction
  task automatic end_round();
    speedExit = 1'b0;
    speedRound = 1'b0;
    repeat (3) tick();
  endtask
  task automatic start_round();
    speedRound = 1'b1;
    repeat (2) tick();
  endtask
  initial begin
    rst = 1'b0; pb = '0; speedRound = 1'b0; speedExit = 1'b0;
    repeat (2) tick();
    check("rst_cnt", int'(cnt_flat), 0);
    check("rst_lead", int'(speed_lead), 0);
    check("rst_tie", int'(speed_tie), 0);
    check("rst_done", int'(speed_done), 0);
    rst = 1'b1;
    start_round();
    check("zero_tie", int'(speed_tie), 1);
    check("zero_lead", int'(speed_lead), 0);
    repeat (3) press(0);
    repeat (2) press(1);
    check("t1_cnt0", cnt(0), 3);
    check("t1_cnt1", cnt(1), 2);
    check("t1_leader", int'(speed_leader), 0);
    check("t1_lead", int'(speed_lead), 1);
    check("t1_tie", int'(speed_tie), 0);
    press(1);
    check("t2_cnt1", cnt(1), 3);
    check("t2_tie", int'(speed_tie), 1);
    check("t2_lead", int'(speed_lead), 0);
    check("t2_leader", int'(speed_leader), 0);
    pb[1] = 1'b1;
    tick();
    check("t2_cnt1_4", cnt(1), 4);
    check("t2_done_lag", int'(speed_done), 0);
    pb[1] = 1'b0;
    tick();
    check("t2_done_tgt", int'(speed_done), int'(TGT));
    check("t2_leader1", int'(speed_leader), 1);
    check("t2_lead1", int'(speed_lead), 1);
    press(1);
    check("t2_cnt1_after", cnt(1), TGT ? 4 : 5);
    speedExit = 1'b1;
    tick();
    check("t2_exit_done", int'(speed_done), 1);
    end_round();
    check("idle_done", int'(speed_done), 0);
    check("idle_tie", int'(speed_tie), 0);
    check("idle_retain", cnt(1), TGT ? 4 : 5);
    start_round();
    check("t3_clear", int'(cnt_flat), 0);
    pb = 4'b1111;
    tick();
    check("t3_cnt_all", int'(cnt_flat), 12'h249);
    pb = '0;
    tick();
    check("t3_tie", int'(speed_tie), 1);
    check("t3_leader", int'(speed_leader), 0);
    check("t3_lead", int'(speed_lead), 0);
    repeat (9) press(2);
    check("t4_sat", cnt(2), TGT ? 4 : 7);
    check("t4_leader", int'(speed_leader), 2);
    check("t4_lead", int'(speed_lead), 1);
    speedExit = 1'b1;
    tick();
    speedExit = 1'b0;
    check("t4_done", int'(speed_done), 1);
    press(2);
    press(0);
    check("t4_frozen2", cnt(2), TGT ? 4 : 7);
    check("t4_frozen0", cnt(0), 1);
    end_round();
    rst = 1'b0;
    pb[0] = 1'b1;
    tick();
    rst = 1'b1;
    start_round();
    tick();
    check("t5_held", cnt(0), 0);
    pb[0] = 1'b0;
    tick();
    repeat (3) press(0);
    repeat (2) press(1);
    check("t5_cnt0", cnt(0), 3);
    check("t5_cnt1", cnt(1), 2);
    rst = 1'b0;
    tick();
    check("t5_rst_cnt", int'(cnt_flat), 0);
    check("t5_rst_lead", int'(speed_lead), 0);
    check("t5_rst_done", int'(speed_done), 0);
    speedRound = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("t5_idle_tie", int'(speed_tie), 0);
    start_round();
    press(3);
    pb[3] = 1'b1;
    speedExit = 1'b1;
    tick();
    pb[3] = 1'b0;
    speedExit = 1'b0;
    tick();
    check("exit_press", cnt(3), 2);
    check("exit_done", int'(speed_done), 1);
    end_round();
    start_round();
    press(1);
    speedRound = 1'b0;
    tick();
    check("drop_done", int'(speed_done), 1);
    tick();
    check("drop_idle", int'(speed_done), 0);
    check("drop_cnt", cnt(1), 1);
    speedRound = 1'b1;
    speedExit = 1'b1;
    repeat (2) tick();
    check("prec_done", int'(speed_done), 0);
    check("prec_tie", int'(speed_tie), 0);
    check("prec_cnt", cnt(1), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
